// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state, byte-enable constants and the bus command payload
// for the data-memory bus bridge.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LH  = 3'b001,
        LD_LHU = 3'b010,
        LD_LB  = 3'b011,
        LD_LBU = 3'b100
    } ltype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;
    localparam logic [BE_W-1:0] BE_LO   = 4'b0011;
    localparam logic [BE_W-1:0] BE_HI   = 4'b1100;
    localparam logic [BE_W-1:0] BE_B0   = 4'b0001;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // Reserved store size and unknown load types fall back to word accesses.
    function automatic logic misaligned(input logic store, input logic [1:0] size,
                                        input logic [2:0] ltype, input logic [1:0] addr_lo);
        logic is_half;
        logic is_byte;
        if (store) begin
            is_half = (size == SZ_HALF);
            is_byte = (size == SZ_BYTE);
        end else begin
            is_half = (ltype == LD_LH) || (ltype == LD_LHU);
            is_byte = (ltype == LD_LB) || (ltype == LD_LBU);
        end
        if (is_byte) return 1'b0;
        if (is_half) return addr_lo[0];
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Little-endian lane steering: store side builds be/replicated wdata, load side
// extracts the addressed lane and sign/zero-extends it.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic              load,
    input  logic [2:0]        sel,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] data_in,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] data_out
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be       = BE_WORD;
        data_out = data_in;
        lane_b   = data_in[{addr_lo, 3'b000} +: 8];
        lane_h   = addr_lo[1] ? data_in[31:16] : data_in[15:0];
        if (load) begin
            case (sel)
                LD_LH:   data_out = {{16{lane_h[15]}}, lane_h};
                LD_LHU:  data_out = {16'h0000, lane_h};
                LD_LB:   data_out = {{24{lane_b[7]}}, lane_b};
                LD_LBU:  data_out = {24'h000000, lane_b};
                default: data_out = data_in;
            endcase
        end else begin
            case (sel[1:0])
                SZ_HALF: begin
                    be       = addr_lo[1] ? BE_HI : BE_LO;
                    data_out = {2{data_in[15:0]}};
                end
                SZ_BYTE: begin
                    be       = BE_B0 << addr_lo;
                    data_out = {4{data_in[7:0]}};
                end
                default: begin
                    be       = BE_WORD;
                    data_out = data_in;
                end
            endcase
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's data-memory port onto a valid/ready system bus with stall,
// misalignment and watchdog reporting. Define DMEM_WBUF_EN for a posted store buffer.
module dmem_bus_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_re,
    input  logic              dmem_we,
    input  logic [1:0]        dmem_inchoice,
    input  logic [2:0]        dmem_outchoice,
    input  logic [DATA_W-1:0] dmem_addrin,
    input  logic [DATA_W-1:0] dmem_in,
    output logic [DATA_W-1:0] dmem_out,
    output logic              cpu_stall,
    output logic              addr_err,
    output logic              addr_err_st,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [BE_W-1:0]   bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    bus_cmd_t          cmd, cmd_d;
    logic              req, req_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              err, err_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        alo_q, alo_d;
    logic              posted, posted_d;
    logic              stall_c;

    logic              misal;
    logic              access_ok;
    logic              timeout_hit;
    logic [BE_W-1:0]   st_be, ld_be;
    logic [DATA_W-1:0] st_wdata, ld_data;

    assign misal       = misaligned(dmem_we, dmem_inchoice, dmem_outchoice, dmem_addrin[1:0]);
    assign access_ok   = (dmem_re || dmem_we) && !misal;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    dmem_lane u_st_lane (
        .load     (1'b0),
        .sel      ({1'b0, dmem_inchoice}),
        .addr_lo  (dmem_addrin[1:0]),
        .data_in  (dmem_in),
        .be       (st_be),
        .data_out (st_wdata)
    );

    dmem_lane u_ld_lane (
        .load     (1'b1),
        .sel      (ltype_q),
        .addr_lo  (alo_q),
        .data_in  (bus_rdata),
        .be       (ld_be),
        .data_out (ld_data)
    );

    // Next-state and registered-output values; everything holds unless overridden.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cmd_d    = cmd;
        req_d    = req;
        out_d    = out_q;
        err_d    = 1'b0;
        ltype_d  = ltype_q;
        alo_d    = alo_q;
        posted_d = posted;
        stall_c  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (access_ok) begin
                    stall_c     = !(WBUF && dmem_we);
                    state_d     = ST_BUS;
                    cnt_d       = '0;
                    req_d       = 1'b1;
                    cmd_d.we    = dmem_we;
                    cmd_d.addr  = {dmem_addrin[31:2], 2'b00};
                    cmd_d.be    = dmem_we ? st_be : ld_be;
                    cmd_d.wdata = st_wdata;
                    ltype_d     = dmem_outchoice;
                    alo_d       = dmem_addrin[1:0];
                    posted_d    = WBUF && dmem_we;
                end
            end
            ST_BUS: begin
                // A draining posted store only holds the core if it presents a new access.
                stall_c = posted ? access_ok : 1'b1;
                cnt_d   = cnt + CNT_W'(1);
                if (bus_ready) begin
                    req_d    = 1'b0;
                    posted_d = 1'b0;
                    state_d  = posted ? ST_IDLE : ST_DONE;
                    if (!posted) out_d = ld_data;
                end else if (timeout_hit) begin
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    posted_d = 1'b0;
                    state_d  = posted ? ST_IDLE : ST_DONE;
                    if (!posted) out_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cmd     <= '0;
            req     <= 1'b0;
            out_q   <= '0;
            err     <= 1'b0;
            ltype_q <= '0;
            alo_q   <= '0;
            posted  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cmd     <= cmd_d;
            req     <= req_d;
            out_q   <= out_d;
            err     <= err_d;
            ltype_q <= ltype_d;
            alo_q   <= alo_d;
            posted  <= posted_d;
        end
    end

    assign cpu_stall   = stall_c && reset;
    assign addr_err    = (dmem_re || dmem_we) && misal;
    assign addr_err_st = addr_err && dmem_we;
    assign bus_req     = req;
    assign bus_we      = cmd.we;
    assign bus_addr    = cmd.addr;
    assign bus_be      = cmd.be;
    assign bus_wdata   = cmd.wdata;
    assign dmem_out    = out_q;
    assign bus_err     = err;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: stimulus queues expected bus commands and
// completions, a negedge monitor compares them against what the bridge presents.
module tb_dmem_bus_bridge;

`ifdef DMEM_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_re, dmem_we;
    logic [1:0]  dmem_inchoice;
    logic [2:0]  dmem_outchoice;
    logic [31:0] dmem_addrin, dmem_in, dmem_out;
    logic        cpu_stall, addr_err, addr_err_st, bus_err;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bexp_t;

    typedef struct {
        int          stall;
        logic        err;
        logic        chk_out;
        logic [31:0] dout;
    } dexp_t;

    bexp_t bus_q[$];
    dexp_t done_q[$];

    int errors = 0;
    int checks = 0;

    int          rdy_delay = 0;
    logic [31:0] rd_val    = 32'h0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_data  = 32'h0;
    logic        mem_valid = 1'b0;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .dmem_re        (dmem_re),
        .dmem_we        (dmem_we),
        .dmem_inchoice  (dmem_inchoice),
        .dmem_outchoice (dmem_outchoice),
        .dmem_addrin    (dmem_addrin),
        .dmem_in        (dmem_in),
        .dmem_out       (dmem_out),
        .cpu_stall      (cpu_stall),
        .addr_err       (addr_err),
        .addr_err_st    (addr_err_st),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: ready after rdy_delay wait cycles; remembers the last written word.
    initial begin
        int wcnt;
        wcnt      = 0;
        bus_ready = 1'b0;
        bus_rdata = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                bus_ready = (wcnt == rdy_delay);
                wcnt++;
            end else begin
                bus_ready = 1'b0;
                wcnt      = 0;
            end
            if (bus_ready) begin
                bus_rdata = (mem_valid && bus_addr == mem_addr) ? mem_data : rd_val;
                if (bus_we) begin
                    mem_addr  = bus_addr;
                    mem_data  = bus_wdata;
                    mem_valid = 1'b1;
                end
            end else begin
                bus_rdata = 32'hDEADBEEF;
            end
        end
    end

    // Monitor: bus command compared every cycle it is presented, completion on stall release.
    initial begin
        int   run;
        logic prev_req;
        logic chk_clr;
        run      = 0;
        prev_req = 1'b0;
        chk_clr  = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                run      = 0;
                prev_req = 1'b0;
                chk_clr  = 1'b0;
                bus_q.delete();
                done_q.delete();
            end else begin
                if (bus_req) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'(bus_req), 32'h0);
                    end else begin
                        chk("bus_we", 32'(bus_we), 32'(bus_q[0].we));
                        chk("bus_addr", bus_addr, bus_q[0].addr);
                        chk("bus_be", 32'(bus_be), 32'(bus_q[0].be));
                        if (bus_q[0].we) chk("bus_wdata", bus_wdata, bus_q[0].wdata);
                    end
                end else if (prev_req && bus_q.size() != 0) begin
                    void'(bus_q.pop_front());
                end
                prev_req = bus_req;

                if (cpu_stall) begin
                    run++;
                end else if (run > 0) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'(run), 32'h0);
                    end else begin
                        dexp_t d;
                        d = done_q.pop_front();
                        chk("stall_cycles", 32'(run), 32'(d.stall));
                        chk("bus_err", 32'(bus_err), 32'(d.err));
                        if (d.chk_out) chk("dmem_out", dmem_out, d.dout);
                        chk_clr = 1'b1;
                    end
                    run = 0;
                end else if (chk_clr) begin
                    chk("bus_err_clear", 32'(bus_err), 32'h0);
                    chk_clr = 1'b0;
                end
            end
        end
    end

    // Core side: present one access and hold it until the stall releases (called at posedge+1).
    task automatic access(input logic re, input logic we, input logic [1:0] sz, input logic [2:0] lt,
                          input logic [31:0] addr, input logic [31:0] din, input logic [31:0] rdata,
                          input int delay, input logic [3:0] ebe, input logic [31:0] ewdata,
                          input int estall, input logic eerr, input logic [31:0] edout, input bit drain);
        bexp_t b;
        dexp_t d;
        bit    ok;
        logic  st;
        b.we    = we;
        b.addr  = {addr[31:2], 2'b00};
        b.be    = ebe;
        b.wdata = ewdata;
        bus_q.push_back(b);
        if (!(we && WBUF)) begin
            d.stall   = estall;
            d.err     = eerr;
            d.chk_out = re;
            d.dout    = edout;
            done_q.push_back(d);
        end
        rdy_delay      = delay;
        rd_val         = rdata;
        dmem_re        = re;
        dmem_we        = we;
        dmem_inchoice  = sz;
        dmem_outchoice = lt;
        dmem_addrin    = addr;
        dmem_in        = din;
        ok             = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            st = cpu_stall;
            @(posedge clk);
            if (!st) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("stall_bound", 32'(cpu_stall), 32'h0);
        #1;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        if (drain) begin
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (!bus_req) break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        dmem_re        = 1'b0;
        dmem_we        = 1'b0;
        dmem_inchoice  = 2'b00;
        dmem_outchoice = 3'b000;
        dmem_addrin    = 32'h0;
        dmem_in        = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_dmem_out", dmem_out, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'h0);

        // sb 0x1003: lane 3, byte replicated
        access(1'b0, 1'b1, 2'b10, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0,
               4'b1000, 32'hDDDD_DDDD, 2, 1'b0, 32'h0, 1'b1);
        // lh / lhu 0x2002 from upper half 0x8001
        access(1'b1, 1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0,
               4'b1111, 32'h0, 2, 1'b0, 32'hFFFF_8001, 1'b1);
        access(1'b1, 1'b0, 2'b00, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0,
               4'b1111, 32'h0, 2, 1'b0, 32'h0000_8001, 1'b1);

        // Misaligned lw then sh: exception only, no bus, no stall
        dmem_re        = 1'b1;
        dmem_outchoice = 3'b000;
        dmem_addrin    = 32'h0000_3001;
        #1;
        chk("lw_mis_addr_err", 32'(addr_err), 32'h1);
        chk("lw_mis_addr_err_st", 32'(addr_err_st), 32'h0);
        chk("lw_mis_stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("lw_mis_bus_req", 32'(bus_req), 32'h0);
        dmem_re       = 1'b0;
        dmem_we       = 1'b1;
        dmem_inchoice = 2'b01;
        dmem_in       = 32'h0000_5555;
        #1;
        chk("sh_mis_addr_err", 32'(addr_err), 32'h1);
        chk("sh_mis_addr_err_st", 32'(addr_err_st), 32'h1);
        chk("sh_mis_stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("sh_mis_bus_req", 32'(bus_req), 32'h0);
        dmem_we = 1'b0;

        // lb 0x4000 with three ready-low cycles
        access(1'b1, 1'b0, 2'b00, 3'b011, 32'h0000_4000, 32'h0, 32'h1234_56F0, 3,
               4'b1111, 32'h0, 5, 1'b0, 32'hFFFF_FFF0, 1'b1);
        // sw 0x5004, one wait cycle
        access(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_5004, 32'hCAFE_BABE, 32'h0, 1,
               4'b1111, 32'hCAFE_BABE, 3, 1'b0, 32'h0, 1'b1);
        // lbu 0x6002 -> byte 2 zero-extended
        access(1'b1, 1'b0, 2'b00, 3'b100, 32'h0000_6002, 32'h0, 32'h00A5_0000, 0,
               4'b1111, 32'h0, 2, 1'b0, 32'h0000_00A5, 1'b1);
        // sh 0x7002 -> upper half lanes
        access(1'b0, 1'b1, 2'b01, 3'b000, 32'h0000_7002, 32'h1234_ABCD, 32'h0, 0,
               4'b1100, 32'hABCD_ABCD, 2, 1'b0, 32'h0, 1'b1);
        // lw 0x8000
        access(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_8000, 32'h0, 32'h89AB_CDEF, 0,
               4'b1111, 32'h0, 2, 1'b0, 32'h89AB_CDEF, 1'b1);
        // Watchdog: 4 BUS cycles then DONE with bus_err and zero data
        access(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_9000, 32'h0, 32'h5555_5555, 100,
               4'b1111, 32'h0, 5, 1'b1, 32'h0, 1'b1);

        // Reset pulsed in the middle of a BUS access
        begin
            bexp_t b;
            b.we    = 1'b0;
            b.addr  = 32'h0000_C000;
            b.be    = 4'b1111;
            b.wdata = 32'h0;
            bus_q.push_back(b);
        end
        rdy_delay      = 100;
        dmem_re        = 1'b1;
        dmem_outchoice = 3'b000;
        dmem_addrin    = 32'h0000_C000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_bus_req", 32'(bus_req), 32'h0);
        chk("rst_mid_stall", 32'(cpu_stall), 32'h0);
        dmem_re = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_dmem_out", dmem_out, 32'h0);

        // Recovery after the abandoned access
        access(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_A000, 32'h0, 32'h0BAD_F00D, 0,
               4'b1111, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 1'b1);

`ifdef DMEM_WBUF_EN
        // Posted sw, then lw to the same word waits for the drain and sees the new data
        access(1'b0, 1'b1, 2'b00, 3'b000, 32'h0000_B000, 32'h1122_3344, 32'h0, 2,
               4'b1111, 32'h1122_3344, 0, 1'b0, 32'h0, 1'b0);
        access(1'b1, 1'b0, 2'b00, 3'b000, 32'h0000_B000, 32'h0, 32'h0, 2,
               4'b1111, 32'h0, 7, 1'b0, 32'h1122_3344, 1'b1);
`endif

        repeat (5) @(posedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
        chk("done_q_empty", 32'(done_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
